crc_stream_engine: RTL and testbench
====================================

# crc_stream_engine

Parametrised, frame-aware CRC generator/checker for the UART byte path. It accepts a valid/ready data stream with an end-of-frame marker and accumulates the CRC over the frame. On the final beat it publishes the CRC, a residue-check flag and the frame length for one cycle, then rearms for the next frame. Width, polynomial, initial value, bit reflection and final XOR are all generics, so one block covers CRC-16/MODBUS, CCITT, CRC-8 and CRC-32 framing.

## Interface
- CRC_W, 16: CRC width, 8..32.
- DATA_W, 8: input beat width, 1..32.
- POLY, 16'h8005: generator polynomial, normal form, implicit top bit.
- INIT, 16'hFFFF: register value at frame start.
- REFIN, 1: 1 = each beat processed LSB first; 0 = MSB first.
- REFOUT, 1: 1 = register bit-reversed before XOROUT.
- XOROUT, 16'h0000: final XOR applied to the output.
- CHECK_RES, 16'h0000: expected output-form value when the frame includes its own appended CRC.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort/restart of the current frame.
- in_valid  in  1  beat present.
- in_data  in  DATA_W  beat data.
- in_last  in  1  beat is the final beat of the frame.
- in_ready  out  1  beat can be accepted.
- busy  out  1  frame in progress (at least one beat accepted, no last yet).
- crc_valid  out  1  one-cycle pulse: crc_out, crc_ok and len_out are fresh.
- crc_out  out  CRC_W  finished CRC (REFOUT and XOROUT applied).
- crc_ok  out  1  crc_out == CHECK_RES for the frame just completed.
- len_out  out  16  beats in the completed frame; saturates at 16'hFFFF.

## Operation
- FSM states:
  - IDLE: register = INIT, busy=0.
  - RUN: accumulating.
  - DONE: one cycle, publish.
- Accept: in_valid && in_ready at a rising edge.
  - in_ready = 1 in IDLE and RUN, 0 in DONE.
  - in_data is ignored when not accepted.
- Per accepted beat: the register advances by DATA_W serial LFSR steps, equivalent to a Galois shift with POLY, combinational within one cycle. Bit order per REFIN.
- Transitions:
  - IDLE, accept, !in_last -> RUN.
  - IDLE or RUN, accept, in_last -> DONE.
  - DONE -> IDLE unconditionally; register reloads INIT.
  - A single-beat frame (last on first beat) is legal.
- Length counter:
  - Increments per accepted beat and saturates at 16'hFFFF.
  - Its final value, including the last beat, is latched to len_out.
  - Clears on entry to IDLE.
- Output form: crc_out = (REFOUT ? bitrev(reg) : reg) ^ XOROUT. It is registered on the last-beat edge and held until the next completed frame.
- crc_ok is registered together with crc_out and held likewise.
- clr:
  - Forces IDLE, register INIT, counter 0, crc_valid 0.
  - crc_out, crc_ok and len_out retain their previous values.
  - clr has priority over a simultaneous accept; that beat is dropped, and in_ready is still 1 that cycle.
- rst mid-frame: everything returns to reset values immediately, with no publish.
- Reset values:
  - state IDLE, register INIT, in_ready 1, busy 0.
  - crc_valid 0, crc_out 0, crc_ok 0, len_out 0.

## Timing
- Throughput: one beat per clock within a frame.
- One dead cycle (DONE, in_ready=0) follows every frame.
- Latency: last beat accepted at edge N -> crc_valid high between edges N and N+1. Outputs are stable at edge N+1.
- crc_valid is high for exactly one cycle per completed frame. It never asserts on clr or rst.
- busy rises the cycle after the first non-last beat is accepted. It falls the cycle after the last beat is accepted.
- No combinational path from in_valid to in_ready. in_ready depends on state only.

## Test plan
- Defaults (MODBUS), "123456789" back-to-back, in_last on '9':
  - crc_out=16'h4B37, len_out=9, crc_valid for 1 cycle, in_ready=0 that cycle.
- Defaults, "123456789" then 8'h37, 8'h4B (last):
  - crc_out=16'h0000, crc_ok=1, len_out=11.
  - Repeat with the last byte corrupted to 8'h4A -> crc_ok=0.
- POLY=16'h1021, INIT=16'hFFFF, REFIN=0, REFOUT=0, "123456789" -> crc_out=16'h29B1.
- CRC_W=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, REFIN=1, REFOUT=1, XOROUT=32'hFFFFFFFF, "123456789" -> 32'hCBF43926.
- Defaults, 4 bytes accepted, then clr together with a valid beat:
  - No crc_valid; the beat is dropped.
  - "123456789" next -> 16'h4B37, len_out=9.
  - Also: rst low mid-frame -> all outputs at reset values, in_ready=1.
- Defaults, in_valid toggled randomly across "123456789", plus a single-beat frame 8'h00 issued immediately after DONE:
  - First frame gives the same 16'h4B37.
  - The single-beat frame yields crc_valid with len_out=1.
  - No beat is accepted during DONE.

Source files
------------

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: frame-aware, fully parametrised CRC generator/checker
// for a valid/ready beat stream. Accumulates over a frame delimited by
// in_last, then publishes CRC, residue-check flag and frame length for one
// cycle before rearming.
module crc_stream_engine #(
    parameter int unsigned      CRC_W     = 16,
    parameter int unsigned      DATA_W    = 8,
    parameter logic [CRC_W-1:0] POLY      = 16'h8005,
    parameter logic [CRC_W-1:0] INIT      = 16'hFFFF,
    parameter bit               REFIN     = 1'b1,
    parameter bit               REFOUT    = 1'b1,
    parameter logic [CRC_W-1:0] XOROUT    = 16'h0000,
    parameter logic [CRC_W-1:0] CHECK_RES = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic [15:0]       len_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_next, crc_form;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic [15:0]      len_q, len_d, len_inc;
    logic [15:0]      len_out_q, len_out_d;
    logic             crc_valid_q, crc_valid_d;
    logic             crc_ok_q, crc_ok_d;
    logic             accept;

    // Bit-serial Galois LFSR unrolled over one beat; REFIN picks the bit order.
    function automatic logic [CRC_W-1:0] crc_advance(input logic [CRC_W-1:0] crc,
                                                     input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] r;
        logic             b;
        logic             fb;
        r = crc;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            b  = REFIN ? data[i] : data[DATA_W-1-i];
            fb = r[CRC_W-1] ^ b;
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) begin
                r = r ^ POLY;
            end
        end
        return r;
    endfunction

    // Register to published form: optional bit reversal, then final XOR.
    function automatic logic [CRC_W-1:0] out_form(input logic [CRC_W-1:0] r);
        logic [CRC_W-1:0] o;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            o[i] = REFOUT ? r[CRC_W-1-i] : r[i];
        end
        return o ^ XOROUT;
    endfunction

    assign in_ready  = (state_q != S_DONE);
    assign busy      = (state_q == S_RUN);
    assign accept    = in_valid && in_ready;
    assign crc_valid = crc_valid_q;
    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;
    assign len_out   = len_out_q;

    // Datapath results for the beat currently on the input.
    always_comb begin
        crc_next = crc_advance(crc_q, in_data);
        crc_form = out_form(crc_next);
        len_inc  = (len_q == '1) ? len_q : len_q + 16'd1;
    end

    // Next-state and publish logic; clr overrides any accept in the same cycle.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        crc_valid_d = 1'b0;
        crc_out_d   = crc_out_q;
        crc_ok_d    = crc_ok_q;
        len_out_d   = len_out_q;
        if (clr) begin
            state_d = S_IDLE;
            crc_d   = INIT;
            len_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (accept) begin
                        crc_d = crc_next;
                        len_d = len_inc;
                        if (in_last) begin
                            state_d     = S_DONE;
                            crc_valid_d = 1'b1;
                            crc_out_d   = crc_form;
                            crc_ok_d    = (crc_form == CHECK_RES);
                            len_out_d   = len_inc;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    crc_d   = INIT;
                    len_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    crc_d   = INIT;
                    len_d   = '0;
                end
            endcase
        end
    end

    // State, accumulator and published-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            crc_q       <= INIT;
            len_q       <= '0;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            crc_ok_q    <= 1'b0;
            len_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            crc_valid_q <= crc_valid_d;
            crc_out_q   <= crc_out_d;
            crc_ok_q    <= crc_ok_d;
            len_out_q   <= len_out_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Testbench for crc_stream_engine: three configurations (MODBUS, CCITT-FALSE,
// CRC-32) share one stimulus stream and are compared every cycle against a
// byte-wise reference model, plus a table of known check values.
module tb_crc_stream_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        rdy_a, bsy_a, vld_a, ok_a;
    logic [15:0] crc_a, len_a;
    logic        rdy_b, bsy_b, vld_b, ok_b;
    logic [15:0] crc_b, len_b;
    logic        rdy_c, bsy_c, vld_c, ok_c;
    logic [31:0] crc_c;
    logic [15:0] len_c;

    always #5 clk = ~clk;

    crc_stream_engine dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_a), .busy(bsy_a), .crc_valid(vld_a),
        .crc_out(crc_a), .crc_ok(ok_a), .len_out(len_a)
    );

    crc_stream_engine #(
        .POLY(16'h1021), .INIT(16'hFFFF), .REFIN(1'b0), .REFOUT(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_b), .busy(bsy_b), .crc_valid(vld_b),
        .crc_out(crc_b), .crc_ok(ok_b), .len_out(len_b)
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1),
        .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF), .CHECK_RES(32'h2144DF1C)
    ) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_c), .busy(bsy_c), .crc_valid(vld_c),
        .crc_out(crc_c), .crc_ok(ok_c), .len_out(len_c)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: frame contents and published results.
    logic [7:0]  m_frame[$];
    int          m_len;
    bit          m_done;
    bit          m_valid;
    logic [31:0] m_crc[3];
    bit          m_ok[3];
    logic [15:0] m_len_out;

    typedef struct {
        logic [7:0]  data[12];
        int          n;
        bit          has_a;
        logic [15:0] ea;
        bit          eok;
        logic [15:0] elen;
        bit          has_b;
        logic [15:0] eb;
        bit          has_c;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Classic byte-at-a-time CRC: XOR the (optionally reflected) byte into
    // the top of the register, then eight polynomial-division shifts.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bit refin,
                                            input bit refout, input logic [31:0] xorout,
                                            input logic [7:0] q[$]);
        logic [63:0] r, mask, top;
        logic [7:0]  b;
        logic [31:0] o;
        mask = (64'd1 << w) - 64'd1;
        top  = 64'd1 << (w - 1);
        r    = {32'd0, init};
        foreach (q[j]) begin
            b = q[j];
            if (refin) b = {<<{b}};
            r = r ^ ({56'd0, b} << (w - 8));
            for (int k = 0; k < 8; k++) begin
                if ((r & top) != 64'd0) r = ((r << 1) ^ {32'd0, poly}) & mask;
                else                    r = (r << 1) & mask;
            end
        end
        o = '0;
        if (refout) begin
            for (int i = 0; i < w; i++) o[i] = r[w-1-i];
        end else begin
            o = r[31:0];
        end
        return o ^ xorout;
    endfunction

    task automatic publish();
        m_crc[0] = ref_crc(16, 32'h8005, 32'hFFFF, 1'b1, 1'b1, 32'h0, m_frame);
        m_crc[1] = ref_crc(16, 32'h1021, 32'hFFFF, 1'b0, 1'b0, 32'h0, m_frame);
        m_crc[2] = ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, m_frame);
        m_ok[0]   = (m_crc[0] == 32'h0);
        m_ok[1]   = (m_crc[1] == 32'h0);
        m_ok[2]   = (m_crc[2] == 32'h2144DF1C);
        m_len_out = 16'(m_len);
    endtask

    task automatic check_all();
        chk("ready_a", rdy_a, !m_done);
        chk("ready_b", rdy_b, !m_done);
        chk("ready_c", rdy_c, !m_done);
        chk("busy_a", bsy_a, m_frame.size() != 0);
        chk("busy_b", bsy_b, m_frame.size() != 0);
        chk("busy_c", bsy_c, m_frame.size() != 0);
        chk("valid_a", vld_a, m_valid);
        chk("valid_b", vld_b, m_valid);
        chk("valid_c", vld_c, m_valid);
        chk("crc_a", crc_a, m_crc[0][15:0]);
        chk("crc_b", crc_b, m_crc[1][15:0]);
        chk("crc_c", crc_c, m_crc[2]);
        chk("ok_a", ok_a, m_ok[0]);
        chk("ok_b", ok_b, m_ok[1]);
        chk("ok_c", ok_c, m_ok[2]);
        chk("len_a", len_a, m_len_out);
        chk("len_b", len_b, m_len_out);
        chk("len_c", len_c, m_len_out);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit c);
        bit acc;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        clr      = c;
        acc      = v && !m_done && !c;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (c || m_done) begin
            m_frame.delete();
            m_len  = 0;
            m_done = 1'b0;
        end else if (acc) begin
            m_frame.push_back(d);
            if (m_len < 65535) m_len++;
            if (l) begin
                publish();
                m_valid = 1'b1;
                m_done  = 1'b1;
                m_frame.delete();
                m_len = 0;
            end
        end
        check_all();
    endtask

    task automatic do_reset(input bit check_async);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        clr      = 1'b0;
        #2;
        m_frame.delete();
        m_len     = 0;
        m_done    = 1'b0;
        m_valid   = 1'b0;
        m_crc     = '{default: 32'h0};
        m_ok      = '{default: 1'b0};
        m_len_out = 16'h0;
        if (check_async) check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    // Offer bytes with random idle gaps until all are accepted.
    task automatic send_frame(input logic [7:0] bytes[$], input int gap_pct, input bit fin);
        int i;
        int guard;
        bit v;
        bit acc;
        i     = 0;
        guard = 0;
        while (i < bytes.size() && guard < 2000) begin
            v   = ($urandom_range(99) >= gap_pct);
            acc = v && !m_done;
            if (v) cycle(1'b1, bytes[i], fin && (i == bytes.size() - 1), 1'b0);
            else   cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0);
            if (acc) i++;
            guard++;
        end
        if (guard >= 2000) chk("send_timeout", guard, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] frame[$];
        int         n;

        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 12; j++) tbl[t].data[j] = 8'h31 + 8'(j);
            tbl[t].n     = 9;
            tbl[t].has_a = 1'b1;
            tbl[t].has_b = 1'b0;
            tbl[t].has_c = 1'b0;
            tbl[t].eb    = 16'h0;
            tbl[t].ec    = 32'h0;
        end
        tbl[0].ea = 16'h4B37; tbl[0].eok = 1'b0; tbl[0].elen = 16'd9;
        tbl[0].has_b = 1'b1; tbl[0].eb = 16'h29B1;
        tbl[0].has_c = 1'b1; tbl[0].ec = 32'hCBF43926;
        tbl[1].data[9] = 8'h37; tbl[1].data[10] = 8'h4B; tbl[1].n = 11;
        tbl[1].ea = 16'h0000; tbl[1].eok = 1'b1; tbl[1].elen = 16'd11;
        tbl[2].data[9] = 8'h37; tbl[2].data[10] = 8'h4A; tbl[2].n = 11;
        tbl[2].has_a = 1'b0; tbl[2].ea = 16'h0; tbl[2].eok = 1'b0; tbl[2].elen = 16'd11;
        tbl[3].data[0] = 8'h00; tbl[3].n = 1;
        tbl[3].ea = 16'h40BF; tbl[3].eok = 1'b0; tbl[3].elen = 16'd1;

        do_reset(1'b0);

        // Known-answer frames, back-to-back beats.
        for (int t = 0; t < 4; t++) begin
            frame.delete();
            for (int j = 0; j < tbl[t].n; j++) frame.push_back(tbl[t].data[j]);
            send_frame(frame, 0, 1'b1);
            chk($sformatf("tbl%0d_valid", t), vld_a, 1);
            chk($sformatf("tbl%0d_ready", t), rdy_a, 0);
            if (tbl[t].has_a) chk($sformatf("tbl%0d_crc16", t), crc_a, tbl[t].ea);
            chk($sformatf("tbl%0d_ok", t), ok_a, tbl[t].eok);
            chk($sformatf("tbl%0d_len", t), len_a, tbl[t].elen);
            if (tbl[t].has_b) chk($sformatf("tbl%0d_ccitt", t), crc_b, tbl[t].eb);
            if (tbl[t].has_c) chk($sformatf("tbl%0d_crc32", t), crc_c, tbl[t].ec);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_pulse", t), vld_a, 0);
        end

        // clr with a simultaneous valid beat after four bytes.
        frame = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_frame(frame, 0, 1'b0);
        in_valid = 1'b1; in_data = 8'h35; in_last = 1'b0; clr = 1'b1;
        #1;
        chk("clr_ready", rdy_a, 1);
        cycle(1'b1, 8'h35, 1'b0, 1'b1);
        chk("clr_novalid", vld_a, 0);
        chk("clr_busy", bsy_a, 0);
        frame.delete();
        for (int j = 0; j < 9; j++) frame.push_back(8'h31 + 8'(j));
        send_frame(frame, 0, 1'b1);
        chk("after_clr_crc", crc_a, 16'h4B37);
        chk("after_clr_len", len_a, 16'd9);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-frame.
        frame = '{8'h31, 8'h32, 8'h33};
        send_frame(frame, 0, 1'b0);
        do_reset(1'b1);
        chk("rst_ready", rdy_a, 1);
        chk("rst_crc", crc_a, 0);
        chk("rst_len", len_a, 0);

        // Gappy "123456789", then a single-beat frame offered during DONE.
        frame.delete();
        for (int j = 0; j < 9; j++) frame.push_back(8'h31 + 8'(j));
        send_frame(frame, 40, 1'b1);
        chk("gap_crc", crc_a, 16'h4B37);
        chk("gap_len", len_a, 16'd9);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        chk("done_drop_valid", vld_a, 0);
        chk("done_drop_len", len_a, 16'd9);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        chk("single_valid", vld_a, 1);
        chk("single_len", len_a, 16'd1);
        chk("single_crc", crc_a, 16'h40BF);

        // Random frames with random gaps and occasional aborts.
        for (int f = 0; f < 40; f++) begin
            frame.delete();
            n = $urandom_range(16, 1);
            for (int j = 0; j < n; j++) frame.push_back(8'($urandom));
            if ($urandom_range(4) == 0) begin
                send_frame(frame, 30, 1'b0);
                cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            end else begin
                send_frame(frame, 30, 1'b1);
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
